exe_stage: RTL
==============

EXE_STAGE -- requirements
Module: exe_stage

Interface
REQ-001 SHALL have one clock and an asynchronous, active-high reset; no other clock or reset exists.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-004 state  input  4  global multicycle state code (`STATE_IF, `STATE_ID, `STATE_EX1..`STATE_EX4, `STATE_MEM, `STATE_WB from head.h).
REQ-005 next_state  output  4  state requested for the next cycle while in any EX state.
REQ-006 ds_to_es_valid  input  1  decode holds a valid instruction this cycle.
REQ-007 ds_to_es_bus  input  152  MSB to LSB: alu_op[12], load_op, src1_is_pc, src2_is_imm, src2_is_4, gr_we, mem_we, dest[5], imm[32], rj_value[32], rkd_value[32], pc[32], res_from_mem.
REQ-008 es_to_ms_valid  output  1  es_to_ms_bus is valid.
REQ-009 es_to_ms_bus  output  71  MSB to LSB: res_from_mem, gr_we, dest[5], alu_result[32], pc[32].
REQ-010 data_sram_en  output  1  data SRAM access enable.
REQ-011 data_sram_we  output  4  byte write strobes.
REQ-012 data_sram_addr  output  32  byte address.
REQ-013 data_sram_wdata  output  32  store data.

Function
REQ-014 SHALL capture ds_to_es_bus into es_bus_r on every rising edge with ds_to_es_valid=1; otherwise es_bus_r holds.
REQ-015 SHALL set es_valid_r on that same edge and clear it on the first edge where state is not an EX state.
REQ-016 ALU inputs: src1 = pc when src1_is_pc, else rj_value; src2 = imm when src2_is_imm, else rkd_value; all operands are taken from es_bus_r.
REQ-017 alu_op one-hot, bit 0 to bit 11:
- add
- sub
- signed slt
- unsigned sltu
- and
- nor
- or
- xor
- sll
- srl
- sra
- lui (result = src2)
REQ-018 Arithmetic is 32-bit wrap-around with no overflow flag; shifts use src2[4:0] only; slt/sltu produce 0 or 1 zero-extended.
REQ-019 If alu_op is all-zero, the result SHALL be 0; if more than one bit is set, the result SHALL be the OR of the selected results.
REQ-020 SHALL register alu_result into alu_result_r at the end of every EX2 or EX3 cycle while es_valid_r=1.
REQ-021 es_to_ms_bus SHALL present the es_bus_r fields together with alu_result_r.
REQ-022 es_to_ms_valid SHALL be 1 only during `STATE_MEM or `STATE_WB that directly follows an EX2/EX3 cycle in which es_valid_r=1.
REQ-023 next_state by current state:
- EX1 (branch; resolved upstream) -> `STATE_IF
- EX2 (ALU) -> `STATE_WB
- EX3 (load) -> `STATE_MEM
- EX4 (store) -> `STATE_IF
- any other state -> `STATE_IF
REQ-024 EX3: data_sram_en=1, we=0, addr=alu_result (combinational, same cycle), so read data returns in MEM.
REQ-025 EX4: data_sram_en=1, we=4'hf only when mem_we=1 (else 0), addr=alu_result, wdata=rkd_value.
REQ-026 Outside EX3/EX4, or when es_valid_r=0, data_sram_en=0 and we=0; addr and wdata are don't-care but SHALL be driven 0.
REQ-027 An EX cycle with es_valid_r=0 SHALL issue no SRAM access, leave alu_result_r unchanged, and drive next_state=`STATE_IF.
REQ-028 If ds_to_es_valid=1 coincides with an EX state, the new bus SHALL be captured, with the current cycle's access using the old es_bus_r contents.

Reset
REQ-029 While reset is asserted, including mid-EX or mid-access:
- es_bus_r=0, alu_result_r=0, es_valid_r=0
- es_to_ms_valid=0, data_sram_en=0, data_sram_we=0, data_sram_addr=0, data_sram_wdata=0
- next_state=`STATE_IF
REQ-030 After reset deasserts, the block SHALL perform no action until a new ds_to_es_valid capture.

Verification
REQ-031 add.w: rj=0x7FFFFFFF, rkd=1, capture, state EX2 -> next_state=WB; in WB es_to_ms_valid=1 with alu_result=0x80000000.
REQ-032 sltu vs slt: rj=0xFFFFFFFF, rkd=1 -> sltu result 0, slt result 1; srai with imm=33 -> shift by 1.
REQ-033 ld.w: rj=0x1000, imm=0xFFFFFFFC, state EX3 -> data_sram_en=1, we=0, addr=0x0FFC in that cycle, next_state=MEM; in MEM es_to_ms_bus res_from_mem=1.
REQ-034 st.w: rj=0x2000, imm=8, rkd=0xDEADBEEF, state EX4 -> en=1, we=4'hf, addr=0x2008, wdata=0xDEADBEEF, next_state=IF; next cycle en=0.
REQ-035 Reset asserted asynchronously mid-EX4 -> en and we drop to 0 before the next clk edge; after release in EX2 with no capture -> next_state=IF, es_to_ms_valid=0.
REQ-036 EX1 with a valid capture -> next_state=IF, no SRAM access, alu_result_r unchanged.

Source files
------------

// File: rtl/exe_stage.sv
// Execute stage of a multicycle core: latches the decoded instruction, runs the ALU,
// drives the data SRAM in EX3/EX4 and hands the result to MEM/WB.
package exe_stage_pkg;

  typedef enum logic [3:0] {
    ST_IF  = 4'd0,
    ST_ID  = 4'd1,
    ST_EX1 = 4'd2,
    ST_EX2 = 4'd3,
    ST_EX3 = 4'd4,
    ST_EX4 = 4'd5,
    ST_MEM = 4'd6,
    ST_WB  = 4'd7
  } state_e;

  typedef struct packed {
    logic [11:0] alu_op;
    logic        load_op;
    logic        src1_is_pc;
    logic        src2_is_imm;
    logic        src2_is_4;
    logic        gr_we;
    logic        mem_we;
    logic [4:0]  dest;
    logic [31:0] imm;
    logic [31:0] rj_value;
    logic [31:0] rkd_value;
    logic [31:0] pc;
    logic        res_from_mem;
  } es_bus_t;

endpackage

module exe_stage
  import exe_stage_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic [3:0]   state,
  output logic [3:0]   next_state,
  input  logic         ds_to_es_valid,
  input  logic [151:0] ds_to_es_bus,
  output logic         es_to_ms_valid,
  output logic [70:0]  es_to_ms_bus,
  output logic         data_sram_en,
  output logic [3:0]   data_sram_we,
  output logic [31:0]  data_sram_addr,
  output logic [31:0]  data_sram_wdata
);

  es_bus_t     r_es_bus;
  logic        r_es_valid;
  logic [31:0] r_alu_result;
  logic        r_fwd_valid;

  state_e      w_state;
  logic        w_is_ex;
  logic        w_alu_cycle;
  logic [31:0] w_src1;
  logic [31:0] w_src2;
  logic [4:0]  w_shamt;
  logic [31:0] w_alu_result;
  logic        w_unused_bits;

  assign w_state     = state_e'(state);
  assign w_is_ex     = (w_state == ST_EX1) || (w_state == ST_EX2) ||
                       (w_state == ST_EX3) || (w_state == ST_EX4);
  assign w_alu_cycle = r_es_valid && ((w_state == ST_EX2) || (w_state == ST_EX3));

  // Decode-side flags that this stage carries but does not act on.
  assign w_unused_bits = &{1'b0, r_es_bus.load_op, r_es_bus.src2_is_4};

  assign w_src1  = r_es_bus.src1_is_pc  ? r_es_bus.pc  : r_es_bus.rj_value;
  assign w_src2  = r_es_bus.src2_is_imm ? r_es_bus.imm : r_es_bus.rkd_value;
  assign w_shamt = w_src2[4:0];

  // alu_op is nominally one-hot; ORing masked results gives 0 for no op and the
  // bitwise OR for illegal multi-hot codes without extra priority logic.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    w_alu_result = '0;
    if (r_es_bus.alu_op[0])  w_alu_result |= w_src1 + w_src2;
    if (r_es_bus.alu_op[1])  w_alu_result |= w_src1 - w_src2;
    if (r_es_bus.alu_op[2])  w_alu_result |= {31'd0, $signed(w_src1) < $signed(w_src2)};
    if (r_es_bus.alu_op[3])  w_alu_result |= {31'd0, w_src1 < w_src2};
    if (r_es_bus.alu_op[4])  w_alu_result |= w_src1 & w_src2;
    if (r_es_bus.alu_op[5])  w_alu_result |= ~(w_src1 | w_src2);
    if (r_es_bus.alu_op[6])  w_alu_result |= w_src1 | w_src2;
    if (r_es_bus.alu_op[7])  w_alu_result |= w_src1 ^ w_src2;
    if (r_es_bus.alu_op[8])  w_alu_result |= w_src1 << w_shamt;
    if (r_es_bus.alu_op[9])  w_alu_result |= w_src1 >> w_shamt;
    if (r_es_bus.alu_op[10]) w_alu_result |= $unsigned($signed(w_src1) >>> w_shamt);
    if (r_es_bus.alu_op[11]) w_alu_result |= w_src2;
  end

  always_ff @(posedge clk or posedge reset) begin
    // NOTE: state updates use non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      r_es_bus     <= '0;
      r_es_valid   <= 1'b0;
      r_alu_result <= '0;
      r_fwd_valid  <= 1'b0;
    end else begin
      if (ds_to_es_valid) r_es_bus <= es_bus_t'(ds_to_es_bus);
      // A fresh capture wins over the leave-EX clear so an ID-cycle capture survives.
      if (ds_to_es_valid)  r_es_valid <= 1'b1;
      else if (!w_is_ex)   r_es_valid <= 1'b0;
      if (w_alu_cycle)     r_alu_result <= w_alu_result;
      r_fwd_valid <= w_alu_cycle;
    end
  end

  always_comb begin
    next_state      = ST_IF;
    data_sram_en    = 1'b0;
    data_sram_we    = 4'h0;
    data_sram_addr  = '0;
    data_sram_wdata = '0;
    if (r_es_valid) begin
      case (w_state)
        ST_EX2: next_state = ST_WB;
        ST_EX3: begin
          next_state     = ST_MEM;
          data_sram_en   = 1'b1;
          data_sram_addr = w_alu_result;
        end
        ST_EX4: begin
          data_sram_en    = 1'b1;
          data_sram_we    = r_es_bus.mem_we ? 4'hf : 4'h0;
          data_sram_addr  = w_alu_result;
          data_sram_wdata = r_es_bus.rkd_value;
        end
        default: ;
      endcase
    end
  end

  assign es_to_ms_valid = r_fwd_valid && ((w_state == ST_MEM) || (w_state == ST_WB));
  assign es_to_ms_bus   = {r_es_bus.res_from_mem, r_es_bus.gr_we, r_es_bus.dest,
                           r_alu_result, r_es_bus.pc};

endmodule
